cfg_sram_array: RTL and testbench
=================================

Name: cfg_sram_array

Overview:
- Parametrised, multi-bit successor to the 1-bit scan-loadable config SRAM.
- Flop-based storage with:
  - one synchronous write port;
  - one read port, combinational or registered;
  - a serial scan chain through every stored bit.
- A scan-load controller counts shifted bits and flags when the full configuration image has been loaded.
- Sits in each CLB/LUT tile as the configuration store, daisy-chained via scan_in/scan_out.

Parameters:
- ADDR_WIDTH, 4: address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 1: bits per word.
- READ_LATENCY, 0: 0 = combinational rdata; 1 = registered rdata.
- CNT_WIDTH, derived: clog2(DEPTH*DATA_WIDTH); must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- raddr  input  ADDR_WIDTH  read address.
- rdata  output  DATA_WIDTH  read data.
- scan_en  input  1  shift the chain one bit this cycle.
- scan_in  input  1  serial chain input.
- scan_out  output  1  serial chain output.
- scan_restart  input  1  synchronously clears the load counter and cfg_loaded; data is untouched.
- scan_cnt  output  CNT_WIDTH  bits shifted in the current load pass.
- cfg_loaded  output  1  full image shifted in since the last reset/restart.

Behaviour:
- Reset (asynchronous, immediate): all storage = 0, rdata = 0, scan_out = 0, scan_cnt = 0, cfg_loaded = 0, FSM = IDLE.
- Flat bit index: f = addr*DATA_WIDTH + bit; TOTAL = DEPTH*DATA_WIDTH.
- Shift (scan_en=1, we=0):
  - f[0] <= scan_in;
  - f[i] <= f[i-1] for all i > 0.
- scan_out = f[TOTAL-1], combinational from storage.
- Write (we=1): mem[waddr] <= wdata at the clock edge.
- Priority: rst > we > scan_restart > scan_en.
  - With we=1, no shift occurs and the counter holds.
  - scan_restart with scan_en: restart wins, no shift.
- Read path:
  - READ_LATENCY=0: rdata = mem[raddr] combinationally; reflects a write or shift after the edge.
  - READ_LATENCY=1: rdata <= mem[raddr] at each edge; old data is returned on a same-cycle write collision.
- Scan FSM states:
  - IDLE: scan_cnt = 0, cfg_loaded = 0.
    - Shift -> SHIFTING, cnt = 1.
    - If TOTAL = 1, a shift goes directly to LOADED.
  - SHIFTING: each shift increments cnt.
    - The shift at cnt = TOTAL-1 wraps cnt to 0, sets cfg_loaded -> LOADED.
    - scan_en low: hold (pause is legal, any length).
  - LOADED: cfg_loaded stays 1.
    - Further shifts continue (readback/pass-through) and cnt counts modulo TOTAL.
    - cfg_loaded is never cleared by shifting.
  - Any state: scan_restart -> IDLE (cnt = 0, cfg_loaded = 0).
- Width rules:
  - scan_cnt wraps exactly at TOTAL, not at 2**CNT_WIDTH.
  - Widths are unsigned, no truncation of addresses.
- Mid-operation reset: the load is aborted and all bits are 0; the next load starts from cnt = 0.

Decomposition:
- Package cfg_sram_pkg:
  - FSM state encoding (IDLE = 0, SHIFTING = 1, LOADED = 2);
  - clog2 function;
  - READ_LATENCY legal values.
- Sub-module cfg_scan_ctrl: FSM and bit counter. Inputs: scan_en, we, scan_restart. Outputs: shift_en, scan_cnt, cfg_loaded.
- Top: storage array, read mux/register and shift datapath.

Test Plan:
All scenarios use ADDR_WIDTH=2, DATA_WIDTH=2, so TOTAL = 8.
1. Assert rst mid-cycle -> immediately rdata=0, scan_out=0, scan_cnt=0, cfg_loaded=0, all words 0.
2. we=1, waddr=2, wdata=2'b11, raddr=2 -> rdata=3 right after the edge (LAT=0) or one edge later (LAT=1). Same-cycle read of addr 2 with LAT=1 returns 0.
3. Shift serial stream 1,0,0,0,0,0,0,0 -> after 8th edge mem[3]=2'b10, scan_out=1, scan_cnt=0, cfg_loaded=1. cfg_loaded stays 0 through edges 1-7, with scan_cnt=1..7.
4. 3 shifts, scan_en=0 for 5 cycles, then 5 shifts -> scan_cnt holds 3 during pause; cfg_loaded rises only on the 8th shift.
5. we=1 and scan_en=1 together (waddr=0, wdata=2'b01) -> write performed, no shift, scan_cnt unchanged. Separately, scan_restart after load -> cfg_loaded=0, scan_cnt=0, data intact.
6. rst asserted after 5 shifts -> instant zeroing; a fresh 8-shift load then sets cfg_loaded.

Source files
------------

// File: rtl/cfg_sram_pkg.sv
// cfg_sram_pkg: shared types and helpers for the scan-loadable configuration SRAM.
// Revision 1.0
`default_nettype none

package cfg_sram_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHIFTING = 2'd1,
    S_LOADED   = 2'd2
  } scan_state_t;

  localparam int RL_COMB = 0;
  localparam int RL_REG  = 1;

  // Ceiling log2, never below 1 so a single-bit array still gets a counter bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_scan_ctrl.sv
// cfg_scan_ctrl: scan-load FSM and modulo-TOTAL bit counter.
// Revision 1.0
`default_nettype none

module cfg_scan_ctrl
  import cfg_sram_pkg::*;
#(
  parameter int TOTAL     = 16,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  input  logic                 we,
  input  logic                 scan_restart,
  output logic                 shift_en,
  output logic [CNT_WIDTH-1:0] scan_cnt,
  output logic                 cfg_loaded
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TOTAL - 1);

  scan_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 at_last;

  // A write blocks both shifting and restart; restart blocks shifting.
  assign shift_en = scan_en & ~we & ~scan_restart;
  assign at_last  = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (shift_en) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE:     state_d = at_last ? S_LOADED : S_SHIFTING;
        S_SHIFTING: state_d = at_last ? S_LOADED : S_SHIFTING;
        S_LOADED:   state_d = S_LOADED;
        default:    state_d = S_IDLE;
      endcase
    end else if (scan_restart && !we) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    scan_cnt   = cnt_q;
    cfg_loaded = (state_q == S_LOADED);
  end

endmodule

`default_nettype wire

// File: rtl/cfg_sram_array.sv
// cfg_sram_array: flop-based configuration SRAM with write port, read port and scan chain.
// Revision 1.0
`default_nettype none

module cfg_sram_array
  import cfg_sram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 1,
  parameter int READ_LATENCY = RL_COMB,
  parameter int CNT_WIDTH    = clog2_min1((2 ** ADDR_WIDTH) * DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  scan_en,
  input  logic                  scan_in,
  output logic                  scan_out,
  input  logic                  scan_restart,
  output logic [CNT_WIDTH-1:0]  scan_cnt,
  output logic                  cfg_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int TOTAL = DEPTH * DATA_WIDTH;

  // Flat storage: bit f = addr*DATA_WIDTH + bit, bit 0 is the chain head.
  logic [TOTAL-1:0]      mem_q, mem_d;
  logic                  shift_en;
  logic [DATA_WIDTH-1:0] rd_word;

  cfg_scan_ctrl #(
    .TOTAL     (TOTAL),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_scan_ctrl (
    .clk          (clk),
    .rst          (rst),
    .scan_en      (scan_en),
    .we           (we),
    .scan_restart (scan_restart),
    .shift_en     (shift_en),
    .scan_cnt     (scan_cnt),
    .cfg_loaded   (cfg_loaded)
  );

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[int'(waddr) * DATA_WIDTH +: DATA_WIDTH] = wdata;
    end else if (shift_en) begin
      mem_d    = mem_q << 1;
      mem_d[0] = scan_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rd_word  = mem_q[int'(raddr) * DATA_WIDTH +: DATA_WIDTH];
  assign scan_out = mem_q[TOTAL-1];

  generate
    if (READ_LATENCY == RL_REG) begin : g_rd_reg
      // Samples pre-edge contents, so a colliding write returns old data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else     rdata <= rd_word;
      end
    end else begin : g_rd_comb
      assign rdata = rd_word;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cfg_sram_array.sv
// tb_cfg_sram_array: directed vector bench, ADDR_WIDTH=2 DATA_WIDTH=2, both read latencies.
// Revision 1.0
`default_nettype none

module tb_cfg_sram_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [1:0] waddr, wdata, raddr;
  logic       scan_en, scan_in, scan_restart;
  logic [1:0] rdata0, rdata1;
  logic       so0, so1, ld0, ld1;
  logic [2:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_sram_array #(.ADDR_WIDTH(2), .DATA_WIDTH(2), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata0), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so0),
    .scan_restart(scan_restart), .scan_cnt(cnt0), .cfg_loaded(ld0)
  );

  cfg_sram_array #(.ADDR_WIDTH(2), .DATA_WIDTH(2), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata1), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so1),
    .scan_restart(scan_restart), .scan_cnt(cnt1), .cfg_loaded(ld1)
  );

  typedef struct {
    string      name;
    logic       we;
    logic [1:0] waddr;
    logic [1:0] wdata;
    logic [1:0] raddr;
    logic       scan_en;
    logic       scan_in;
    logic       scan_restart;
    logic [1:0] exp_rd0;
    logic [1:0] exp_rd1;
    logic       exp_so;
    logic [2:0] exp_cnt;
    logic       exp_ld;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] wa, input logic [1:0] wd,
                       input logic [1:0] ra, input logic se, input logic si, input logic sr);
    we = w; waddr = wa; wdata = wd; raddr = ra;
    scan_en = se; scan_in = si; scan_restart = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_scan(input string tag, input logic [2:0] c, input logic l);
    check({tag, " cnt0"}, cnt0, c);
    check({tag, " cnt1"}, cnt1, c);
    check({tag, " loaded0"}, ld0, l);
    check({tag, " loaded1"}, ld1, l);
  endtask

  task automatic check_zero_now(input string tag);
    check({tag, " rdata0"}, rdata0, 0);
    check({tag, " rdata1"}, rdata1, 0);
    check({tag, " scan_out"}, so0, 0);
    check_scan(tag, 3'd0, 1'b0);
    for (int a = 0; a < 4; a++) begin
      raddr = 2'(a);
      #1;
      check($sformatf("%s word%0d", tag, a), rdata0, 0);
    end
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic [1:0] wa,
                              input logic [1:0] wd, input logic [1:0] ra, input logic se,
                              input logic si, input logic sr, input logic [1:0] r0,
                              input logic [1:0] r1, input logic so, input logic [2:0] c,
                              input logic l);
    vec_t v;
    v.name = n; v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra;
    v.scan_en = se; v.scan_in = si; v.scan_restart = sr;
    v.exp_rd0 = r0; v.exp_rd1 = r1; v.exp_so = so; v.exp_cnt = c; v.exp_ld = l;
    return v;
  endfunction

  initial begin
    // name          we wa wd ra se si sr  rd0 rd1 so cnt ld
    vecs.push_back(mk("write2",   1, 2, 3, 2, 0, 0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk("read2",    0, 0, 0, 2, 0, 0, 0, 3, 3, 0, 0, 0));
    vecs.push_back(mk("shift1",   0, 0, 0, 3, 1, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("shift2",   0, 0, 0, 3, 1, 0, 0, 3, 1, 1, 2, 0));
    vecs.push_back(mk("shift3",   0, 0, 0, 3, 1, 0, 0, 2, 3, 1, 3, 0));
    vecs.push_back(mk("shift4",   0, 0, 0, 3, 1, 0, 0, 0, 2, 0, 4, 0));
    vecs.push_back(mk("shift5",   0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 5, 0));
    vecs.push_back(mk("shift6",   0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 6, 0));
    vecs.push_back(mk("shift7",   0, 0, 0, 3, 1, 0, 0, 1, 0, 0, 7, 0));
    vecs.push_back(mk("shift8",   0, 0, 0, 3, 1, 0, 0, 2, 1, 1, 0, 1));
    vecs.push_back(mk("we_vs_se", 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk("shift_ld", 0, 0, 0, 3, 1, 0, 0, 0, 2, 0, 1, 1));
    vecs.push_back(mk("restart",  0, 0, 0, 0, 1, 1, 1, 2, 2, 0, 0, 0));
    vecs.push_back(mk("hold",     0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check_zero_now("por");
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr,
            vecs[i].scan_en, vecs[i].scan_in, vecs[i].scan_restart);
      tick();
      check({vecs[i].name, " rdata0"}, rdata0, vecs[i].exp_rd0);
      check({vecs[i].name, " rdata1"}, rdata1, vecs[i].exp_rd1);
      check({vecs[i].name, " scan_out0"}, so0, vecs[i].exp_so);
      check({vecs[i].name, " scan_out1"}, so1, vecs[i].exp_so);
      check_scan(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_ld);
    end

    // Asynchronous reset asserted between edges with nonzero contents.
    drive(0, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    check_zero_now("midrst");
    rst = 1'b0;
    tick();

    // Three shifts, five-cycle pause, five more shifts.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 3, 1, 1, 0);
      tick();
      check_scan($sformatf("pre_pause%0d", i), 3'(i + 1), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 3, 0, 1, 0);
      tick();
      check_scan($sformatf("pause%0d", i), 3'd3, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 3, 1, 0, 0);
      tick();
      check_scan($sformatf("post_pause%0d", i), 3'((i + 4) % 8), (i == 4));
    end
    check("pause_word3", rdata0, 2'd3);
    check("pause_scan_out", so0, 1'b1);

    // Restart keeps data, then reset aborts a partial load.
    drive(0, 0, 0, 3, 0, 0, 1);
    tick();
    check_scan("restart2", 3'd0, 1'b0);
    check("restart2 word3", rdata0, 2'd3);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 3, 1, 1, 0);
      tick();
      check_scan($sformatf("part%0d", i), 3'(i + 1), 1'b0);
    end
    drive(0, 0, 0, 3, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    check_zero_now("abort");
    rst = 1'b0;
    tick();

    begin
      logic [7:0] pat;
      pat = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
        drive(0, 0, 0, 0, 1, pat[7 - i], 0);
        tick();
        check_scan($sformatf("reload%0d", i), 3'((i + 1) % 8), (i == 7));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("reload scan_out", so0, 1'b1);
    for (int a = 0; a < 4; a++) begin
      logic [1:0] exp_w [4];
      exp_w[0] = 2'd2; exp_w[1] = 2'd0; exp_w[2] = 2'd3; exp_w[3] = 2'd2;
      raddr = 2'(a);
      #1;
      check($sformatf("reload word%0d", a), rdata0, exp_w[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
